// File: rtl/ifu_fetch_req.sv
// ifu_fetch_req: PC owner issuing credit-limited instruction fetches and queueing in-order responses for IF/ID.
module ifu_fetch_req #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_flag_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic [2:0]        hold_flag_i,
  output logic              ibus_req_valid_o,
  input  logic              ibus_req_ready_i,
  output logic [ADDR_W-1:0] ibus_req_addr_o,
  input  logic              ibus_rsp_valid_i,
  output logic              ibus_rsp_ready_o,
  input  logic [DATA_W-1:0] ibus_rsp_data_i,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic              inst_valid_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [DATA_W-1:0] INST_NOP = DATA_W'(32'h13);
  localparam logic [2:0] HOLD_IF = 3'd2;
  logic [ADDR_W-1:0] pc;
  logic [CW-1:0] outstanding, drop_cnt, q_count;
  logic [PW-1:0] a_wp, a_rp, q_wp, q_rp;
  logic [ADDR_W-1:0] a_mem [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic can_req, hold_en, req_fire, rsp_keep, rsp_drop, pop;
  // Credits cover in-flight, to-be-dropped and queued words, so the queue can never overflow.
  assign can_req = (outstanding + drop_cnt + q_count) < CW'(DEPTH);
  assign hold_en = hold_flag_i >= HOLD_IF;
  assign ibus_req_valid_o = can_req & !jump_flag_i & !rst;
  assign ibus_req_addr_o = pc;
  assign ibus_rsp_ready_o = !rst;
  assign req_fire = ibus_req_valid_o & ibus_req_ready_i;
  assign rsp_keep = ibus_rsp_valid_i & ibus_rsp_ready_o & (drop_cnt == '0);
  assign rsp_drop = ibus_rsp_valid_i & ibus_rsp_ready_o & (drop_cnt != '0);
  assign inst_valid_o = (q_count != '0) & !jump_flag_i & !rst;
  assign inst_o = inst_valid_o ? q_data[q_rp] : INST_NOP;
  assign inst_addr_o = inst_valid_o ? q_addr[q_rp] : '0;
  assign pop = inst_valid_o & !hold_en;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      outstanding <= '0;
      drop_cnt <= '0;
      q_count <= '0;
      a_wp <= '0;
      a_rp <= '0;
      q_wp <= '0;
      q_rp <= '0;
    end else if (jump_flag_i) begin
      // Everything still in flight becomes stale; a response landing now is already one of them.
      pc <= jump_addr_i;
      drop_cnt <= outstanding + drop_cnt - CW'(ibus_rsp_valid_i);
      outstanding <= '0;
      q_count <= '0;
      a_wp <= '0;
      a_rp <= '0;
      q_wp <= '0;
      q_rp <= '0;
    end else begin
      if (req_fire) begin
        pc <= pc + ADDR_W'(4);
        a_mem[a_wp] <= pc;
        a_wp <= a_wp + PW'(1);
      end
      if (rsp_keep) begin
        q_data[q_wp] <= ibus_rsp_data_i;
        q_addr[q_wp] <= a_mem[a_rp];
        q_wp <= q_wp + PW'(1);
        a_rp <= a_rp + PW'(1);
      end
      if (pop) q_rp <= q_rp + PW'(1);
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_keep);
      drop_cnt <= drop_cnt - CW'(rsp_drop);
      q_count <= q_count + CW'(rsp_keep) - CW'(pop);
    end
  end
endmodule
